// File: rtl/led_sweep_decoder.sv
// Receive-side monitor for the bouncing 3-wide LED bar: recovers position and
// direction, counts reversals, and flags malformed patterns, jumps and stalls.
module led_sweep_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 20000000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [9:0]  LED_IN,
    input  logic        CLR_ERR,
    output logic [3:0]  POS,
    output logic        POS_VALID,
    output logic        DIR,
    output logic        STEP,
    output logic [15:0] SWEEP_COUNT,
    output logic        PATTERN_ERR,
    output logic        STALL
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ACQUIRE,
        TRACK,
        RUN
    } state_e;

    logic [9:0]    sync1_q, sync2_q, acc_q;
    logic [SW-1:0] stab_q;
    logic          accept;

    state_e        state_q;
    logic [3:0]    pos_q;
    logic          valid_q, dir_q, step_q, err_q, stall_q;
    logic [15:0]   sweep_q;
    logic [TW-1:0] stall_cnt_q, stall_cnt_d;

    logic [4:0]    dec;
    logic          new_valid, is_up, is_dn, is_step, rev_legal;
    logic [3:0]    new_pos;
    logic          step_d, to_acq, err_set;

    // Returns {valid, pos}; LED bit 0 sits at window bit 2, so edge runs map to 0/1/10/11.
    function automatic logic [4:0] decode(input logic [9:0] v);
        logic [4:0] r;
        logic [9:0] run3;
        r    = '0;
        run3 = 10'b0000000111;
        if (v == 10'b0000000001)      r = {1'b1, 4'd0};
        else if (v == 10'b0000000011) r = {1'b1, 4'd1};
        else if (v == 10'b1100000000) r = {1'b1, 4'd10};
        else if (v == 10'b1000000000) r = {1'b1, 4'd11};
        else begin
            for (int i = 0; i < 8; i++) begin
                if (v == (run3 << i)) r = {1'b1, 4'(i + 2)};
            end
        end
        return r;
    endfunction

    // A value is accepted once after holding STABLE_CYCLES cycles; re-settling on the
    // already accepted value (e.g. after a short glitch) is not a new event.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
            acc_q   <= '0;
            stab_q  <= '0;
        end else begin
            sync1_q <= LED_IN;
            sync2_q <= sync1_q;
            if (sync1_q != sync2_q)
                stab_q <= '0;
            else if (stab_q != STABLE_MAX)
                stab_q <= stab_q + 1'b1;
            if (accept)
                acc_q <= sync2_q;
        end
    end

    assign accept = (stab_q == STABLE_LAST) && (sync2_q != acc_q);

    always_comb begin
        dec         = decode(sync2_q);
        new_valid   = dec[4];
        new_pos     = dec[3:0];
        is_up       = (new_pos == pos_q + 4'd1);
        is_dn       = ((new_pos + 4'd1) == pos_q);
        is_step     = is_up || is_dn;
        rev_legal   = dir_q ? (pos_q == 4'd11) : (pos_q == 4'd0);
        step_d      = accept && new_valid && (state_q != ACQUIRE) && is_step;
        to_acq      = accept && !new_valid;
        err_set     = to_acq
                   || (accept && new_valid && (state_q != ACQUIRE) && !is_step)
                   || (step_d && (state_q == RUN) && (is_up != dir_q) && !rev_legal);
        stall_cnt_d = stall_cnt_q;
        if (step_d || to_acq)
            stall_cnt_d = '0;
        else if (stall_cnt_q != TIMEOUT_MAX)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Tracking FSM; all outputs are registered here.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ACQUIRE;
            pos_q       <= '0;
            valid_q     <= 1'b0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            sweep_q     <= '0;
            err_q       <= 1'b0;
            stall_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            step_q      <= step_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= (stall_cnt_d == TIMEOUT_MAX);
            if (err_set)
                err_q <= 1'b1;
            else if (CLR_ERR)
                err_q <= 1'b0;
            if (accept) begin
                if (!new_valid) begin
                    valid_q <= 1'b0;
                    state_q <= ACQUIRE;
                end else begin
                    pos_q   <= new_pos;
                    valid_q <= 1'b1;
                    case (state_q)
                        ACQUIRE: state_q <= TRACK;
                        TRACK: begin
                            if (is_step) begin
                                dir_q   <= is_up;
                                state_q <= RUN;
                            end
                        end
                        RUN: begin
                            if (!is_step) begin
                                state_q <= TRACK;
                            end else if (is_up != dir_q) begin
                                dir_q   <= is_up;
                                sweep_q <= sweep_q + 16'd1;
                            end
                        end
                        default: state_q <= ACQUIRE;
                    endcase
                end
            end
        end
    end

    assign POS         = pos_q;
    assign POS_VALID   = valid_q;
    assign DIR         = dir_q;
    assign STEP        = step_q;
    assign SWEEP_COUNT = sweep_q;
    assign PATTERN_ERR = err_q;
    assign STALL       = stall_q;

endmodule
